// File: rtl/seq_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_arbiter
// Function : Shares one serial sequence detector among N_REQ requesters.
//            Each granted frame is streamed into det_w, and the det_z hits
//            are counted and returned to the winner.
// Option   : SEQ_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest)
// Revision : 1.0  initial release
// ============================================================================
module seq_det_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] bit_in_i,
  input  logic             det_z_i,
  output logic             det_w_o,
  output logic             det_clr_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic             streaming_o,
  output logic             done_o,
  output logic             abort_o,
  output logic [2:0]       done_id_o,
  output logic [CNT_W-1:0] hit_cnt_o
);

  localparam logic [2:0]       S_IDLE     = 3'd0;
  localparam logic [2:0]       S_CLR      = 3'd1;
  localparam logic [2:0]       S_STREAM   = 3'd2;
  localparam logic [2:0]       S_DRAIN    = 3'd3;
  localparam logic [2:0]       S_DONE     = 3'd4;
  localparam logic [7:0]       C_LAST_BIT = 8'(FRAME_LEN - 1);
  localparam logic [2:0]       C_LAST_REQ = 3'(N_REQ - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [N_REQ-1:0] C_ONE      = N_REQ'(1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       win_q;
  logic [N_REQ-1:0] gnt_q;
  logic [7:0]       bit_idx_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [2:0]       done_id_q;
  logic             aborted_q;

  logic [7:0]       w_req_pad;
  logic [7:0]       w_bit_pad;
  logic             w_any_req;
  logic             w_win_req;
  logic             w_sample;
  logic             w_enter_done;
  logic [2:0]       w_pick;

  assign w_req_pad    = 8'(req_i);
  assign w_bit_pad    = 8'(bit_in_i);
  assign w_any_req    = |req_i;
  assign w_win_req    = w_req_pad[win_q];
  assign w_enter_done = (state_d == S_DONE);

  // z lags w by one clock, so the first STREAM cycle carries no result
  assign w_sample = ((state_q == S_STREAM) && (bit_idx_q != 8'd0)) ||
                    (state_q == S_DRAIN);
  assign cnt_d    = (w_sample && det_z_i && (cnt_q != C_CNT_MAX)) ?
                    cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

`ifdef SEQ_ARB_FIXED_PRIO_EN
  always_comb begin
    w_pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) w_pick = 3'(i);
    end
  end
`else
  logic [2:0] rr_ptr_q;
  logic [3:0] w_cand;
  logic       w_found;

  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = {1'b0, rr_ptr_q} + 4'(i);
      if (w_cand >= 4'(N_REQ)) w_cand = w_cand - 4'(N_REQ);
      if (!w_found && w_req_pad[w_cand[2:0]]) begin
        w_pick  = w_cand[2:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rr_ptr_q <= '0;
    else if (w_enter_done) rr_ptr_q <= (win_q == C_LAST_REQ) ? 3'd0 : win_q + 3'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_any_req) state_d = S_CLR;
      S_CLR:    state_d = w_win_req ? S_STREAM : S_DONE;
      S_STREAM: begin
        if (!w_win_req)                   state_d = S_DONE;
        else if (bit_idx_q == C_LAST_BIT) state_d = S_DRAIN;
      end
      S_DRAIN:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    det_w_o     = 1'b0;
    det_clr_o   = 1'b0;
    streaming_o = 1'b0;
    done_o      = 1'b0;
    abort_o     = 1'b0;
    case (state_q)
      S_CLR:    det_clr_o = 1'b1;
      S_STREAM: begin
        det_w_o     = w_bit_pad[win_q];
        streaming_o = 1'b1;
      end
      S_DONE:   begin
        done_o  = !aborted_q;
        abort_o = aborted_q;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= '0;
      gnt_q     <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      hit_cnt_q <= '0;
      done_id_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   if (w_any_req) begin
          win_q <= w_pick;
          gnt_q <= C_ONE << w_pick;
        end
        S_CLR:    begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
        end
        S_STREAM: begin
          cnt_q <= cnt_d;
          if (bit_idx_q != C_LAST_BIT) bit_idx_q <= bit_idx_q + 8'd1;
        end
        S_DRAIN:  cnt_q <= cnt_d;
        default:  ;
      endcase
      // a dropped request (from CLR, STREAM or DRAIN) reports abort with a zero count
      if (w_enter_done) begin
        gnt_q     <= '0;
        done_id_q <= win_q;
        aborted_q <= !w_win_req;
        hit_cnt_q <= w_win_req ? cnt_d : '0;
      end
    end
  end

  assign gnt_o     = gnt_q;
  assign done_id_o = done_id_q;
  assign hit_cnt_o = hit_cnt_q;

endmodule
`default_nettype wire
